// File: rtl/tencount_ctrl.sv
// Start/stop/clear controller for a decade counter: debounced keys drive an
// IDLE/RUN/PAUSE FSM and a prescaler that emits a count-enable every DIV cycles.

module tencount_db #(
  parameter int unsigned DB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);
  logic [1:0] sync_q;
  logic       acc_q, acc_dly_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      acc_q     <= 1'b0;
      acc_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      acc_dly_q <= acc_q;
      // any cycle where the synchronized key agrees with the accepted level restarts the run
      if (sync_q[1] != acc_q) begin
        if (cnt_q == 8'(DB_LEN - 1)) begin
          acc_q <= ~acc_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = acc_q & ~acc_dly_q;
endmodule

module tencount_ctrl #(
  parameter int unsigned DIV    = 10,
  parameter int unsigned DB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_ss,
  input  logic key_clr,
  input  logic co,
  input  logic stop_on_co,
  output logic en,
  output logic clr,
  output logic run
);
  localparam int unsigned NUM_KEYS = 2;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_RUN    = 2'd1;
  localparam logic [1:0]  S_PAUSE  = 2'd2;
  localparam logic [15:0] LAST     = 16'(DIV - 1);

  logic [NUM_KEYS-1:0] keys, press;
  logic                ss_p, clr_p;
  logic [1:0]          state_q, state_d;
  logic [15:0]         presc_q, presc_d;
  logic                clr_q, clr_d, run_q;

  assign keys = {key_clr, key_ss};

  genvar k;
  generate
    for (k = 0; k < NUM_KEYS; k++) begin : g_key
      tencount_db #(.DB_LEN(DB_LEN)) u_db (
        .clk    (clk),
        .rst    (rst),
        .key_i  (keys[k]),
        .press_o(press[k])
      );
    end
  endgenerate

  assign ss_p  = press[0];
  assign clr_p = press[1];
  assign en    = (state_q == S_RUN) && (presc_q == LAST);

  always_comb begin
    state_d = (state_q == S_RUN || state_q == S_PAUSE) ? state_q : S_IDLE;
    clr_d   = 1'b0;
    // clear beats a carry stop, which beats a start/stop press
    if (clr_p) begin
      state_d = S_IDLE;
      clr_d   = 1'b1;
    end else if (en && stop_on_co && co) begin
      state_d = S_IDLE;
    end else if (ss_p) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end

    // the edge leaving RUN for PAUSE holds the count, so resume continues from it
    if (state_d == S_IDLE)
      presc_d = '0;
    else if (state_q == S_RUN && state_d == S_RUN)
      presc_d = (presc_q == LAST) ? 16'd0 : presc_q + 16'd1;
    else
      presc_d = presc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clr_q   <= clr_d;
      run_q   <= (state_d == S_RUN);
    end
  end

  assign clr = clr_q;
  assign run = run_q;
endmodule

// File: tb/tb_tencount_ctrl.sv
// Randomized bench for tencount_ctrl against a behavioural model of key
// acceptance, the run/pause/idle mode and the tick counter.

module tb_tencount_ctrl;
  localparam int DIV    = 10;
  localparam int DB_LEN = 4;

  logic clk = 1'b0;
  logic rst, key_ss, key_clr, co, stop_on_co;
  logic en, clr, run;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  tencount_ctrl #(.DIV(DIV), .DB_LEN(DB_LEN)) dut (
    .clk(clk), .rst(rst), .key_ss(key_ss), .key_clr(key_clr), .co(co),
    .stop_on_co(stop_on_co), .en(en), .clr(clr), .run(run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model: mode 0=idle 1=run 2=pause, m_cnt = ticks into the period
  int m_mode, m_cnt;
  bit m_clr;
  bit m_raw1[2], m_raw2[2];   // raw key seen one and two edges ago
  bit m_acc[2], m_accp[2];
  int m_rl[2];

  function automatic bit m_en();
    return (m_mode == 1) && (m_cnt == DIV - 1);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cnt = 0; m_clr = 0;
    for (int k = 0; k < 2; k++) begin
      m_raw1[k] = 0; m_raw2[k] = 0; m_acc[k] = 0; m_accp[k] = 0; m_rl[k] = 0;
    end
  endtask

  task automatic m_step();
    bit en_now, ssp, clp;
    bit raw[2];
    en_now = m_en();
    ssp = m_acc[0] && !m_accp[0];
    clp = m_acc[1] && !m_accp[1];
    m_clr = 0;
    if (clp) begin
      m_mode = 0; m_cnt = 0; m_clr = 1;
    end else if (en_now && stop_on_co && co) begin
      m_mode = 0; m_cnt = 0;
    end else if (ssp) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (m_mode == 1) begin
      m_cnt = (m_cnt + 1) % DIV;
    end
    raw[0] = key_ss; raw[1] = key_clr;
    for (int k = 0; k < 2; k++) begin
      m_accp[k] = m_acc[k];
      if (m_raw2[k] != m_acc[k]) begin
        m_rl[k]++;
        if (m_rl[k] == DB_LEN) begin
          m_acc[k] = ~m_acc[k];
          m_rl[k] = 0;
        end
      end else begin
        m_rl[k] = 0;
      end
      m_raw2[k] = m_raw1[k];
      m_raw1[k] = raw[k];
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en", en, m_en());
      chk("clr", clr, m_clr);
      chk("run", run, m_mode == 1);
      chk("en_clr_excl", en & clr, 0);
    end
  end

  // ---- stimulus
  task automatic rand_phase(input int ncyc);
    int hold_ss = 0, hold_clr = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (hold_ss == 0) begin
        key_ss  = $urandom_range(0, 1);
        hold_ss = $urandom_range(1, 12);
      end else hold_ss--;
      if (hold_clr == 0) begin
        key_clr  = ($urandom_range(0, 7) == 0);
        hold_clr = $urandom_range(1, 14);
      end else hold_clr--;
      co = $urandom_range(0, 1);
    end
  endtask

  task automatic reach_run(output bit ok);
    ok = 0;
    @(negedge clk);
    key_ss = 1; key_clr = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (i == 8) key_ss = 0;
      if (m_mode == 1) ok = 1;
    end
    if (!ok) chk("reach_run_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    rst = 0; key_ss = 1; key_clr = 1; co = 0; stop_on_co = 0;
    #1 chk_on = 1;
    repeat (5) @(negedge clk);

    // keys held across reset release: both register as one simultaneous press -> clear only
    rst = 1;
    repeat (12) @(negedge clk);
    key_ss = 0; key_clr = 0;
    repeat (12) @(negedge clk);

    // start latency and first tick
    key_ss = 1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == 12) key_ss = 0;
      if (e == 6)  chk("run_pre_edge7", run, 0);
      if (e == 7)  chk("run_edge7", run, 1);
      if (e == 15) chk("en_first_pre", en, 0);
      if (e == 16) chk("en_first", en, 1);
    end
    repeat (10) @(negedge clk);

    // bouncy press must not be accepted
    key_ss = 1; repeat (3) @(negedge clk);
    key_ss = 0; @(negedge clk);
    key_ss = 1; repeat (3) @(negedge clk);
    key_ss = 0; repeat (15) @(negedge clk);
    chk("bounce_still_run", run, 1);

    // pause then resume
    key_ss = 1; repeat (8) @(negedge clk);
    key_ss = 0; repeat (20) @(negedge clk);
    chk("paused", run, 0);
    key_ss = 1; repeat (8) @(negedge clk);
    key_ss = 0; repeat (20) @(negedge clk);

    // simultaneous ss and clr while running
    key_ss = 1; key_clr = 1; repeat (8) @(negedge clk);
    key_ss = 0; key_clr = 0; repeat (30) @(negedge clk);
    chk("clr_then_idle", run, 0);

    rand_phase(2000);

    // mid-run reset aborts at once; stop_on_co changes only under reset
    reach_run(ok);
    #2 rst = 0;
    #1 chk("rst_async_run", run, 0);
    chk("rst_async_en", en, 0);
    chk("rst_async_clr", clr, 0);
    key_ss = 0; key_clr = 0; stop_on_co = 1;
    @(negedge clk); rst = 1;
    repeat (20) @(negedge clk);
    chk("idle_after_rst", run, 0);

    // carry stop: co held high through a whole run
    reach_run(ok);
    co = 1;
    repeat (DIV + 4) @(negedge clk);
    chk("stopped_on_co", run, 0);
    co = 0;

    rand_phase(2000);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tencount_ctrl.md
TENCOUNT_CTRL -- requirements
Module: tencount_ctrl

Interface
REQ-001 Parameter DIV, default 10: en tick period in clk cycles while running; legal range 2..65535.
REQ-002 Parameter DB_LEN, default 4: consecutive stable cycles required to accept a key level change; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 key_ss  input  1  raw start/stop key, active-high, asynchronous to clk, may bounce.
REQ-006 key_clr  input  1  raw clear key, active-high, asynchronous to clk, may bounce.
REQ-007 co  input  1  carry from the downstream decade counter, sampled only in cycles where en=1.
REQ-008 stop_on_co  input  1  when 1, the run ends at decade wrap; static during operation.
REQ-009 en  output  1  count-enable tick to the decade counter.
REQ-010 clr  output  1  one-cycle active-high clear to the decade counter.
REQ-011 run  output  1  1 while the FSM is in RUN.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level toggles only after the synchronized input differs from it for DB_LEN consecutive cycles.
REQ-013 A press SHALL be a one-cycle pulse on the rising edge of the accepted level; a release SHALL produce no event.
REQ-014 A stable raw key rise SHALL update state, run and clr exactly DB_LEN+3 clock edges after the first edge sampling it high.
REQ-015 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-016 IDLE to RUN on ss press; RUN to PAUSE on ss press; PAUSE to RUN on ss press.
REQ-017 clr press SHALL force IDLE from any state, assert clr for exactly one cycle, and zero the prescaler.
REQ-018 Simultaneous ss and clr presses SHALL be treated as clr only.
REQ-019 Prescaler SHALL count 0..DIV-1 and wrap, incrementing only in RUN, holding in PAUSE, and forced to 0 in IDLE.
REQ-020 en SHALL be 1 exactly in cycles where state=RUN and prescaler=DIV-1, giving a 1-cycle pulse every DIV cycles.
REQ-021 The first en after IDLE to RUN SHALL occur DIV cycles after run rises; after PAUSE to RUN, at DIV minus the held count.
REQ-022 If stop_on_co=1 and co=1 in a cycle with en=1, the FSM SHALL go to IDLE at that edge; clr is not asserted and the counter wraps to 0 on that same tick.
REQ-023 A clr press in the same cycle as the REQ-022 stop SHALL take priority and assert clr.
REQ-024 en and clr SHALL never be 1 in the same cycle.
REQ-025 run SHALL be registered and glitch-free; en SHALL be decoded only from registered state.

Reset
REQ-026 While rst=0, without waiting for a clock edge: state=IDLE, prescaler=0, synchronizers and debounce counters=0, accepted levels=0, en=0, clr=0, run=0.
REQ-027 Reset asserted mid-run SHALL abort immediately with no en or clr pulse; on release the FSM SHALL remain in IDLE until a new press.
REQ-028 A key held high across reset release SHALL register as one press, since the accepted level restarts at 0.

Verification (DIV=10, DB_LEN=4, stop_on_co=0 unless stated)
REQ-029 rst=0 for 5 cycles with both keys high -> en=0, clr=0, run=0 throughout.
REQ-030 key_ss high 12 cycles from IDLE -> run=1 at edge 7; first en 10 cycles later; en 1 cycle wide every 10 cycles.
REQ-031 key_ss pattern high 3, low 1, high 3, low -> no state change; run stays 0.
REQ-032 ss press in RUN with prescaler=4 -> run=0, en held 0; ss press again -> next en 6 cycles after run returns to 1.
REQ-033 key_ss and key_clr rise in the same cycle during RUN -> clr high exactly 1 cycle, run=0, prescaler=0, no en afterwards.
REQ-034 stop_on_co=1, co=1 driven during the 10th en -> IDLE at that edge, run=0, clr stays 0, no further en.
